pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 65 ++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction fetch PC controller with RUN/BUBBLE/HALT sequencing.
// Ports: clk/rst_n (sync, active-low) clock and reset; stall, imem_ready gate fetch acceptance;
// branch/jr/jmp with ext18/target/rs_data select the next PC; halt_req/go stop and resume;
// pc, pc_plus_4 fetch address; fetch_valid, halted state flags; redirect, fetch_cnt status.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             branch,
  input  logic             jr,
  input  logic             jmp,
  input  logic [31:0]      ext18,
  input  logic [19:0]      target,
  input  logic [31:0]      rs_data,
  input  logic             halt_req,
  input  logic             go,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus_4,
  output logic             fetch_valid,
  output logic             halted,
  output logic             redirect,
  output logic [CNT_W-1:0] fetch_cnt
);
  typedef enum logic [1:0] {RUN, BUBBLE, HALT} state_t;
  state_t state, state_n;
  logic adv, jump;
  logic [31:0] next_pc;
  assign pc_plus_4   = pc + 32'd4;
  assign jump        = branch | jr | jmp;
  assign adv         = (state == RUN) & imem_ready & ~stall & ~halt_req;
  assign next_pc     = branch ? pc_plus_4 + ext18 :
                       jr     ? rs_data :
                       jmp    ? {pc[31:22], target, 2'b00} : pc_plus_4;
  assign fetch_valid = state == RUN;
  assign halted      = state == HALT;
  // A taken redirect costs one bubble cycle; halt_req wins over everything in RUN and BUBBLE.
  always_comb begin
    state_n = RUN;
    case (state)
      RUN:     state_n = halt_req ? HALT : (adv & jump) ? BUBBLE : RUN;
      BUBBLE:  state_n = halt_req ? HALT : RUN;
      HALT:    state_n = (go & ~halt_req) ? RUN : HALT;
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      redirect  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state <= state_n;
      if (adv) begin
        pc        <= next_pc;
        fetch_cnt <= fetch_cnt + CNT_W'(1);
        redirect  <= jump;
      end
    end
  end
endmodule
